// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix stream adapter.
// Holds the FSM state encoding, datapath widths, beat counts and the
// fixed order in which operand words arrive on the input stream.
package matrix_pkg;

  localparam int WORD_W = 16;
  localparam int RES_W  = 32;
  localparam int N_OPS  = 8;
  localparam int N_RES  = 4;

  // Position of each operand in the input word sequence.
  localparam logic [2:0] IDX_A11 = 3'd0;
  localparam logic [2:0] IDX_A12 = 3'd1;
  localparam logic [2:0] IDX_A21 = 3'd2;
  localparam logic [2:0] IDX_A22 = 3'd3;
  localparam logic [2:0] IDX_B11 = 3'd4;
  localparam logic [2:0] IDX_B12 = 3'd5;
  localparam logic [2:0] IDX_B21 = 3'd6;
  localparam logic [2:0] IDX_B22 = 3'd7;

  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    WAIT  = 2'b01,
    DRAIN = 2'b10
  } state_t;

endpackage

// File: rtl/matrix_stream_adapter_if.sv
// Operand input stream and result output stream of the adapter.
//   s_valid/s_ready/s_data : 16-bit operand words into the adapter
//   m_valid/m_ready/m_data/m_last : 32-bit result beats out of the adapter
// master = bus side that feeds operands and sinks results; slave = adapter.
interface matrix_stream_adapter_if;
  import matrix_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [RES_W-1:0]  m_data;
  logic              m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/matrix_res_serializer.sv
// Result capture and four-beat output serializer.
//   clk, rst      : clock, async active-low reset
//   capture       : one-cycle pulse; samples c11..c22 and starts the drain
//   c11..c22      : multiplier results
//   m_ready       : downstream accepts the current beat
//   m_valid/m_data/m_last : result beats in order c11, c12, c21, c22
//   done          : pulse on the handshake of the c22 beat
module matrix_res_serializer
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [RES_W-1:0] c11,
  input  logic [RES_W-1:0] c12,
  input  logic [RES_W-1:0] c21,
  input  logic [RES_W-1:0] c22,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [RES_W-1:0] m_data,
  output logic             m_last,
  output logic             done
);

  localparam logic [1:0] LAST_BEAT = 2'(N_RES - 1);

  logic [N_RES-1:0][RES_W-1:0] res_q;
  logic [1:0]                  beat;
  logic                        valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q   <= '0;
      beat    <= '0;
      valid_q <= 1'b0;
    end else if (capture) begin
      res_q   <= {c22, c21, c12, c11};
      beat    <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && m_ready) begin
      // beat wraps 3 -> 0, leaving it ready for the next block
      beat <= beat + 2'd1;
      if (beat == LAST_BEAT) valid_q <= 1'b0;
    end
  end

  // m_data is a mux on held registers, so it cannot move during a stall
  assign m_valid = valid_q;
  assign m_data  = res_q[beat];
  assign m_last  = valid_q && (beat == LAST_BEAT);
  assign done    = valid_q && m_ready && (beat == LAST_BEAT);

endmodule

// File: rtl/matrix_stream_adapter.sv
// Stream front/back end for the 2x2 matrix multiplier core.
// Loads eight operand words, holds them on a11..b22, waits LATENCY edges for
// the combinational/pipelined core to settle, then returns c11..c22 as a
// four-beat output stream.
//   clk, rst        : clock, async active-low reset
//   bus (slave)     : operand input stream and result output stream
//   a11..b22        : registered operands to the multiplier
//   c11..c22        : multiplier results, sampled only on the capture edge
//   busy            : high whenever the FSM is not in LOAD
//
// state | meaning
// LOAD  | accepting operand words, a11 first, b22 last
// WAIT  | operands held, counting LATENCY edges for the core to settle
// DRAIN | presenting the four captured results on the output stream
module matrix_stream_adapter
  import matrix_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_stream_adapter_if.slave bus,
  output logic [WORD_W-1:0]      a11,
  output logic [WORD_W-1:0]      a12,
  output logic [WORD_W-1:0]      a21,
  output logic [WORD_W-1:0]      a22,
  output logic [WORD_W-1:0]      b11,
  output logic [WORD_W-1:0]      b12,
  output logic [WORD_W-1:0]      b21,
  output logic [WORD_W-1:0]      b22,
  input  logic [RES_W-1:0]       c11,
  input  logic [RES_W-1:0]       c12,
  input  logic [RES_W-1:0]       c21,
  input  logic [RES_W-1:0]       c22,
  output logic                   busy
);

  localparam int               CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(LATENCY - 1);

  state_t                      state_q, state_d;
  logic [2:0]                  word_cnt;
  logic [CNT_W-1:0]            wait_cnt;
  logic [N_OPS-1:0][WORD_W-1:0] ops_q;
  logic                        s_ready_int;
  logic                        s_hs;
  logic                        last_word;
  logic                        capture;
  logic                        done;

  assign s_hs      = bus.s_valid && s_ready_int;
  assign last_word = s_hs && (word_cnt == IDX_B22);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LOAD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (last_word)         state_d = WAIT;
      WAIT:    if (wait_cnt == '0)    state_d = DRAIN;
      DRAIN:   if (done)              state_d = LOAD;
      default:                        state_d = LOAD;
    endcase
  end

  always_comb begin
    s_ready_int = (state_q == LOAD) && rst;
    capture     = (state_q == WAIT) && (wait_cnt == '0);
    busy        = (state_q != LOAD);
  end

  // Operand registers and the two down/up counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops_q    <= '0;
      word_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      if (s_hs) begin
        ops_q[word_cnt] <= bus.s_data;
        word_cnt        <= last_word ? 3'd0 : word_cnt + 3'd1;
      end
      // terminal count 0 is the capture edge
      if (last_word)
        wait_cnt <= WAIT_INIT;
      else if (state_q == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign bus.s_ready = s_ready_int;

  assign a11 = ops_q[IDX_A11];
  assign a12 = ops_q[IDX_A12];
  assign a21 = ops_q[IDX_A21];
  assign a22 = ops_q[IDX_A22];
  assign b11 = ops_q[IDX_B11];
  assign b12 = ops_q[IDX_B12];
  assign b21 = ops_q[IDX_B21];
  assign b22 = ops_q[IDX_B22];

  matrix_res_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .c11     (c11),
    .c12     (c12),
    .c21     (c21),
    .c22     (c22),
    .m_ready (bus.m_ready),
    .m_valid (bus.m_valid),
    .m_data  (bus.m_data),
    .m_last  (bus.m_last),
    .done    (done)
  );

endmodule

// File: tb/tb_matrix_stream_adapter.sv
// Two adapters (LATENCY 4 and 1) share one stimulus stream. Each is paired
// with a behavioural 2x2 multiplier whose result settles LATENCY edges after
// the operands change, and is checked every cycle against a transaction-level
// model of the adapter.
module tb_matrix_stream_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        m_ready = 1'b0;

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [7:0][15:0] op_o [2];
  logic             s_ready_o [2];
  logic             m_valid_o [2];
  logic             m_last_o [2];
  logic             busy_o [2];
  logic [31:0]      m_data_o [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // C = A * B, operands in stream order a11,a12,a21,a22,b11,b12,b21,b22
  function automatic logic [3:0][31:0] mul(input logic [7:0][15:0] o);
    logic [31:0] x11, x12, x21, x22, y11, y12, y21, y22;
    logic [3:0][31:0] r;
    x11 = 32'(o[0]); x12 = 32'(o[1]); x21 = 32'(o[2]); x22 = 32'(o[3]);
    y11 = 32'(o[4]); y12 = 32'(o[5]); y21 = 32'(o[6]); y22 = 32'(o[7]);
    r[0] = x11 * y11 + x12 * y21;
    r[1] = x11 * y12 + x12 * y22;
    r[2] = x21 * y11 + x22 * y21;
    r[3] = x21 * y12 + x22 * y22;
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LATG = (g == 0) ? 4 : 1;
    localparam int HI   = (LATG >= 2) ? LATG - 2 : 0;

    matrix_stream_adapter_if bus ();
    logic [15:0] a11, a12, a21, a22, b11, b12, b21, b22;
    logic [31:0] c11, c12, c21, c22;
    logic        busy;
    logic [3:0][31:0] res_now, c_bus;
    logic [3:0][31:0] hist [3];

    assign bus.s_valid = s_valid;
    assign bus.s_data  = s_data;
    assign bus.m_ready = m_ready;

    matrix_stream_adapter #(.LATENCY(LATG)) dut (
      .clk (clk), .rst (rst), .bus (bus),
      .a11 (a11), .a12 (a12), .a21 (a21), .a22 (a22),
      .b11 (b11), .b12 (b12), .b21 (b21), .b22 (b22),
      .c11 (c11), .c12 (c12), .c21 (c21), .c22 (c22),
      .busy (busy)
    );

    assign op_o[g]      = {b22, b21, b12, b11, a22, a21, a12, a11};
    assign s_ready_o[g] = bus.s_ready;
    assign m_valid_o[g] = bus.m_valid;
    assign m_last_o[g]  = bus.m_last;
    assign m_data_o[g]  = bus.m_data;
    assign busy_o[g]    = busy;

    // multiplier core: result of new operands is stable by the LATG-th edge
    assign res_now = mul(op_o[g]);
    always @(posedge clk) begin
      hist[0] <= res_now;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
    end
    assign c_bus = (LATG == 1) ? res_now : hist[HI];
    assign {c22, c21, c12, c11} = c_bus;
  end

  // ---------------- transaction-level model ----------------
  int               md_mode [2];   // 0 loading, 1 settling, 2 draining
  int               md_cnt [2];    // words loaded / edges waited / beats sent
  logic [7:0][15:0] md_ops [2];
  logic [3:0][31:0] md_res [2];
  int               b22_cyc [2];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      md_mode[k] = 0; md_cnt[k] = 0; md_ops[k] = '0; md_res[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    case (md_mode[k])
      0: if (s_valid) begin
           md_ops[k][md_cnt[k]] = s_data;
           if (md_cnt[k] == 7) begin
             md_mode[k] = 1; md_cnt[k] = 0; b22_cyc[k] = cyc;
           end else md_cnt[k]++;
         end
      1: begin
           md_cnt[k]++;
           if (md_cnt[k] == lat_of(k)) begin
             md_mode[k] = 2; md_cnt[k] = 0; md_res[k] = mul(md_ops[k]);
           end
         end
      default: if (m_ready) begin
           if (md_cnt[k] == 3) begin md_mode[k] = 0; md_cnt[k] = 0; end
           else md_cnt[k]++;
         end
    endcase
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_clear();
      else begin
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int k, input logic [127:0] got,
                     input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, k, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: cycle budget expired, got timeout, expected completion", name);
  endtask

  logic [31:0] beat_d [2][8];
  int          beat_n [2];
  int          first_v [2];

  task automatic clear_rec();
    for (int k = 0; k < 2; k++) begin
      beat_n[k] = 0; first_v[k] = -1;
      for (int i = 0; i < 8; i++) beat_d[k][i] = '0;
    end
  endtask

  initial begin
    clear_rec();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("s_ready", k, 128'(s_ready_o[k]), 128'(rst && md_mode[k] == 0));
        chk("m_valid", k, 128'(m_valid_o[k]), 128'(md_mode[k] == 2));
        chk("m_last", k, 128'(m_last_o[k]), 128'(md_mode[k] == 2 && md_cnt[k] == 3));
        chk("busy", k, 128'(busy_o[k]), 128'(md_mode[k] != 0));
        chk("operands", k, 128'(op_o[k]), 128'(md_ops[k]));
        if (md_mode[k] == 2 || !rst)
          chk("m_data", k, 128'(m_data_o[k]),
              128'((md_mode[k] == 2) ? md_res[k][md_cnt[k]] : 32'd0));
        if (m_valid_o[k] && first_v[k] < 0) first_v[k] = cyc;
        if (m_valid_o[k] && m_ready && beat_n[k] < 8) begin
          beat_d[k][beat_n[k]] = m_data_o[k];
          beat_n[k]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic stream(input logic [7:0][15:0] w, input bit gaps, input int n);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    while (i < n && guard < 100) begin
      s_data  = w[i];
      s_valid = gaps ? (guard % 2 == 0) : 1'b1;
      acc     = s_valid && md_mode[0] == 0;
      tick();
      if (acc) i++;
      guard++;
    end
    s_valid = 1'b0;
    if (i < n) timeout("stream");
  endtask

  task automatic wait_idle(input bit stall);
    int guard = 0;
    int held = 0;
    while (!(md_mode[0] == 0 && md_mode[1] == 0) && guard < 200) begin
      if (stall && md_mode[0] == 2 && md_cnt[0] == 1 && held < 3) begin
        m_ready = 1'b0; held++;
      end else m_ready = 1'b1;
      tick();
      guard++;
    end
    m_ready = 1'b1;
    if (guard >= 200) timeout("wait_idle");
  endtask

  task automatic check_res(input string name, input logic [3:0][31:0] exp);
    for (int k = 0; k < 2; k++) begin
      chk({name, "_beats"}, k, 128'(beat_n[k]), 128'(4));
      for (int i = 0; i < 4; i++) chk({name, "_data"}, k, 128'(beat_d[k][i]), 128'(exp[i]));
      // m_valid first seen in the cycle following edge b22_edge + LATENCY
      chk({name, "_latency"}, k, 128'(first_v[k] - b22_cyc[k]), 128'(lat_of(k)));
    end
  endtask

  localparam logic [7:0][15:0] W_SEQ  = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [7:0][15:0] W_ZERO = {16'd0, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [3:0][31:0] E_SEQ  = {32'h32, 32'h2B, 32'h16, 32'h13};
  localparam logic [3:0][31:0] E_ZERO = {32'h12, 32'h2B, 32'h06, 32'h13};

  initial begin
    int guard;
    repeat (3) tick();
    rst = 1'b1;
    m_ready = 1'b1;
    tick();

    clear_rec();
    stream(W_SEQ, 1'b0, 8);
    wait_idle(1'b0);
    check_res("back_to_back", E_SEQ);

    clear_rec();
    stream(W_ZERO, 1'b0, 8);
    wait_idle(1'b0);
    check_res("zero_b22", E_ZERO);

    clear_rec();
    stream(W_SEQ, 1'b1, 8);
    wait_idle(1'b1);
    check_res("gaps_stall", E_SEQ);

    stream(W_SEQ, 1'b0, 5);
    rst = 1'b0;
    #1;
    chk("async_clear_ops", 0, 128'(op_o[0]), 128'(0));
    chk("async_clear_s_ready", 0, 128'(s_ready_o[0]), 128'(0));
    tick(); tick();
    rst = 1'b1;
    tick();
    clear_rec();
    stream(W_SEQ, 1'b0, 8);
    wait_idle(1'b0);
    check_res("reset_mid_load", E_SEQ);

    stream(W_SEQ, 1'b0, 8);
    guard = 0;
    while (!(md_mode[0] == 2 && md_cnt[0] == 2) && guard < 100) begin
      tick(); guard++;
    end
    if (guard >= 100) timeout("reach_beat_2");
    rst = 1'b0;
    #1;
    chk("async_clear_m_valid", 0, 128'(m_valid_o[0]), 128'(0));
    tick(); tick();
    rst = 1'b1;
    tick();
    clear_rec();
    stream(W_SEQ, 1'b0, 8);
    wait_idle(1'b0);
    check_res("reset_mid_drain", E_SEQ);

    repeat (3000) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 16'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      tick();
    end
    s_valid = 1'b0;
    wait_idle(1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
